pio_out_arbiter: RTL and testbench
==================================

Name: pio_out_arbiter

Overview:
Round-robin arbiter sharing the single Avalon-MM slave port of the 8-bit output PIO among NUM_REQ on-chip requesters (SHA-1 core status, debug sequencer, etc.). It serialises requests into single-transfer Avalon writes and reads on the PIO slave, pulses a per-requester acknowledge, and returns read data. It sits between the requesters and the PIO slave inside the base system.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 2, PIO slave address width
DATA_W, 32, Avalon data width

Ports:
clk  in  1  system clock
reset_n  in  1  async active-low reset
req  in  NUM_REQ  per-requester request, held until its ack
req_wr  in  NUM_REQ  1 = write, 0 = read, per requester
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-cycle completion pulse, one-hot
rsp_rdata  out  DATA_W  read data, valid in the ack cycle of a read
busy  out  1  high while a transfer is in progress
gnt_id  out  3  index of the current/last granted requester
m_address  out  ADDR_W  to PIO address
m_chipselect  out  1  to PIO chipselect
m_write_n  out  1  to PIO write_n, active low
m_writedata  out  DATA_W  to PIO writedata
m_readdata  in  DATA_W  from PIO readdata, combinational in the slave

Behaviour:
- Reset (async, reset_n low): state=IDLE; m_chipselect=0; m_write_n=1; m_address=0; m_writedata=0; ack=0; rsp_rdata=0; busy=0; gnt_id=0; rr pointer=NUM_REQ-1, so requester 0 has top priority first.
- All outputs are registered.
- FSM states:
  - IDLE: if any req, register the winner, its address, data and direction → ISSUE; otherwise stay in IDLE.
  - ISSUE: one cycle with m_chipselect=1, m_write_n=~wr, m_address and m_writedata from the winner; busy=1 → ACK.
  - ACK: m_chipselect=0, m_write_n=1; ack[gnt_id]=1 for exactly one cycle; for a read, rsp_rdata=m_readdata sampled at the end of ISSUE; busy=1 → IDLE.
- Latency: req first sampled high at edge t → ISSUE during cycle t..t+1 → ack high in cycle t+1..t+2. Throughput is one transfer per 3 cycles.
- The PIO write commits at the edge ending ISSUE.
- Arbitration: the search starts at pointer+1 mod NUM_REQ, ascending with wrap. The first asserted req wins, and the pointer is set to the winner on grant. Requests are sampled only in IDLE.
- Requester handshake:
  - req and its address, data and direction are held stable from assertion through the ack cycle.
  - req must be low in the cycle after ack unless the requester issues a new request; a still-high req is treated as a new request.
- Requests arriving during ISSUE/ACK wait; none are dropped.
- rsp_rdata holds its value until the next read completes; writes do not alter it.
- Simultaneous requests from all requesters are granted in strict rotation, each once per NUM_REQ transfers.
- A req that drops before it is granted is ignored; no ack is issued. A req that drops after grant still completes and is acked.
- Reset mid-transfer aborts the transfer: outputs return to reset values and no ack is issued. The PIO shares reset_n and also clears.
- Width rules: unused gnt_id MSBs are 0. req_wdata passes unmodified; the PIO uses only bits [7:0].

Decomposition:
- Package pio_arb_pkg:
  - state enum {IDLE, ISSUE, ACK}
  - localparams GNT_W=3 and PIO_DATA_REG_ADDR=0
  - helper function for the packed-slice index
- Sub-module rr_arbiter: combinational round-robin pick from req and pointer, producing winner index and valid. Instantiated once; pointer register kept in the parent.

Test Plan:
- Single write: req[0]=1, wr=1, addr=0, wdata=0x000000A5 → m_chipselect=1, m_write_n=0 for exactly 1 cycle; ack[0] two cycles after sampling; PIO out_port=0xA5.
- Read-back: after the write above, req[2] read at addr=0 → rsp_rdata=0x000000A5 in the ack[2] cycle. Read at addr=1 → rsp_rdata=0.
- Contention: req=4'b1111 held (each re-asserting after ack) from reset → grant order 0,1,2,3,0,1; ack spacing 3 cycles. Writes of 0x11/0x22/0x33/0x44 → out_port follows the same order.
- Fairness after a skip: pointer=1, req=4'b1001 → requester 3 granted before 0.
- Reset mid-transfer: assert reset_n low during ISSUE of a write of 0x5A → no ack; all outputs at reset values; out_port=0x00. After release, req[1] is the first request granted (ack[1]).
- Request withdrawn: req[2] pulses one cycle while a transfer is in ISSUE → never granted, no ack[2]; busy falls 1 cycle after the current ack.

Source files
------------

// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO output arbiter.
// Imported by the interface, the round-robin picker and the top level.
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int GNT_W             = 3;
  localparam int PIO_DATA_REG_ADDR = 0;

  // Low bit of requester idx's field inside a packed per-requester bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/pio_out_arbiter_if.sv
// Requester-side and PIO-side signals of the output arbiter.
// master = the arbiter itself, slave = requesters plus the PIO slave.
interface pio_out_arbiter_if
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;
  logic [GNT_W-1:0]          gnt_id;

  logic [ADDR_W-1:0]         m_address;
  logic                      m_chipselect;
  logic                      m_write_n;
  logic [DATA_W-1:0]         m_writedata;
  logic [DATA_W-1:0]         m_readdata;

  modport master (
    input  req, req_wr, req_addr, req_wdata, m_readdata,
    output ack, rsp_rdata, busy, gnt_id,
           m_address, m_chipselect, m_write_n, m_writedata
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata, m_readdata,
    input  ack, rsp_rdata, busy, gnt_id,
           m_address, m_chipselect, m_write_n, m_writedata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after ptr,
// ascending with wrap. The pointer register lives in the parent.
module rr_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GNT_W-1:0]   ptr,
  output logic [GNT_W-1:0]   winner,
  output logic               valid
);

  localparam int SLOTS = 2 ** GNT_W;

  logic [SLOTS-1:0] req_ext;
  logic [GNT_W-1:0] idx;

  genvar gi;
  for (gi = 0; gi < SLOTS; gi++) begin : g_ext
    if (gi < NUM_REQ) begin : g_used
      assign req_ext[gi] = req[gi];
    end else begin : g_unused
      assign req_ext[gi] = 1'b0;
    end
  end

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == GNT_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      if (!valid && req_ext[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_out_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto the single
// Avalon-MM slave port of the output PIO; one transfer every 3 cycles.
module pio_out_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  pio_out_arbiter_if.master bus
);

  localparam int SLOTS = 2 ** GNT_W;

  state_t            state_reg;
  logic [GNT_W-1:0]  ptr_reg;
  logic              wr_reg;

  logic [GNT_W-1:0]  pick_id;
  logic              pick_valid;
  logic [NUM_REQ-1:0] ack_onehot;

  // Per-requester views padded to a power of two so a GNT_W-bit index is exact.
  logic              wr_arr    [SLOTS];
  logic [ADDR_W-1:0] addr_arr  [SLOTS];
  logic [DATA_W-1:0] wdata_arr [SLOTS];

  genvar gi;
  for (gi = 0; gi < SLOTS; gi++) begin : g_unpack
    if (gi < NUM_REQ) begin : g_used
      assign wr_arr[gi]    = bus.req_wr[gi];
      assign addr_arr[gi]  = bus.req_addr[slice_lo(gi, ADDR_W) +: ADDR_W];
      assign wdata_arr[gi] = bus.req_wdata[slice_lo(gi, DATA_W) +: DATA_W];
    end else begin : g_unused
      assign wr_arr[gi]    = 1'b0;
      assign addr_arr[gi]  = '0;
      assign wdata_arr[gi] = '0;
    end
  end

  for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack
    assign ack_onehot[gi] = (bus.gnt_id == GNT_W'(gi));
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req    (bus.req),
    .ptr    (ptr_reg),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      ptr_reg          <= GNT_W'(NUM_REQ - 1);
      wr_reg           <= 1'b0;
      bus.gnt_id       <= '0;
      bus.ack          <= '0;
      bus.rsp_rdata    <= '0;
      bus.busy         <= 1'b0;
      bus.m_address    <= '0;
      bus.m_chipselect <= 1'b0;
      bus.m_write_n    <= 1'b1;
      bus.m_writedata  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            ptr_reg          <= pick_id;
            bus.gnt_id       <= pick_id;
            wr_reg           <= wr_arr[pick_id];
            bus.m_address    <= addr_arr[pick_id];
            bus.m_writedata  <= wdata_arr[pick_id];
            bus.m_write_n    <= ~wr_arr[pick_id];
            bus.m_chipselect <= 1'b1;
            bus.busy         <= 1'b1;
            state_reg        <= ISSUE;
          end
        end
        ISSUE: begin
          // The PIO slave drives readdata combinationally from m_address.
          if (!wr_reg) begin
            bus.rsp_rdata <= bus.m_readdata;
          end
          bus.m_chipselect <= 1'b0;
          bus.m_write_n    <= 1'b1;
          bus.ack          <= ack_onehot;
          state_reg        <= ACK;
        end
        ACK: begin
          bus.ack   <= '0;
          bus.busy  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_out_arbiter.sv
// Bench for pio_out_arbiter: directed scenarios then random requesters,
// every cycle compared against a transaction-level reference model.
module tb_pio_out_arbiter;
  import pio_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 32;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pio_out_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pio_out_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Stand-in 8-bit output PIO: data register at address 0, shares reset_n.
  logic [7:0] out_port;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= 8'h00;
    else if (bus.m_chipselect && !bus.m_write_n && bus.m_address == '0)
      out_port <= bus.m_writedata[7:0];
  end
  assign bus.m_readdata = (bus.m_address == '0) ? DATA_W'(out_port) : '0;

  // Requester drive
  logic [NUM_REQ-1:0] r_req = '0;
  logic [NUM_REQ-1:0] r_wr  = '0;
  logic [ADDR_W-1:0]  r_addr [NUM_REQ];
  logic [DATA_W-1:0]  r_data [NUM_REQ];
  assign bus.req    = r_req;
  assign bus.req_wr = r_wr;
  always_comb begin
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W]  = r_addr[i];
      bus.req_wdata[i*DATA_W +: DATA_W] = r_data[i];
    end
  end

  // Reference model: one granted transfer described by its grant edge number
  int cyc, ready_edge, g_edge, g_id, ptr;
  logic g_wr;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [7:0] m_port;
  logic [DATA_W-1:0] m_rsp;
  logic [NUM_REQ-1:0] granted, drop_next, acked;
  bit hold_mode, rand_mode;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ready_edge = 0;
    g_edge     = -10;
    g_id       = 0;
    ptr        = NUM_REQ - 1;
    g_wr       = 1'b0;
    g_addr     = '0;
    g_data     = '0;
    m_port     = 8'h00;
    m_rsp      = '0;
    granted    = '0;
    drop_next  = '0;
    acked      = '0;
  endtask

  task automatic raise(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    r_req[i]  = 1'b1;
    r_wr[i]   = wr;
    r_addr[i] = a;
    r_data[i] = d;
  endtask

  task automatic check_reset_outputs();
    chk("rst_chipselect", bus.m_chipselect, 1'b0);
    chk("rst_write_n", bus.m_write_n, 1'b1);
    chk("rst_address", bus.m_address, '0);
    chk("rst_writedata", bus.m_writedata, '0);
    chk("rst_ack", bus.ack, '0);
    chk("rst_rsp_rdata", bus.rsp_rdata, '0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_gnt_id", bus.gnt_id, '0);
    chk("rst_out_port", out_port, 8'h00);
  endtask

  task automatic check_outputs();
    logic cs_e, ack_c;
    cs_e  = (cyc == g_edge);
    ack_c = (cyc == g_edge + 1);
    chk("chipselect", bus.m_chipselect, cs_e);
    chk("write_n", bus.m_write_n, !(cs_e && g_wr));
    chk("ack", bus.ack, ack_c ? (NUM_REQ'(1) << g_id) : '0);
    chk("busy", bus.busy, cs_e || ack_c);
    chk("gnt_id", bus.gnt_id, g_id);
    chk("rsp_rdata", bus.rsp_rdata, m_rsp);
    chk("out_port", out_port, m_port);
    if (cs_e) begin
      chk("address", bus.m_address, g_addr);
      chk("writedata", bus.m_writedata, g_data);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acked[i]) begin
        if (!hold_mode) drop_next[i] = 1'b1;
      end else if (drop_next[i]) begin
        r_req[i]     = 1'b0;
        drop_next[i] = 1'b0;
      end else if (rand_mode) begin
        if (!r_req[i]) begin
          if ($urandom_range(0, 3) == 0)
            raise(i, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 0) ? '0 : ADDR_W'($urandom_range(0, 3)),
                  $urandom);
        end else if (!granted[i] && $urandom_range(0, 19) == 0) begin
          r_req[i] = 1'b0;
        end
      end
    end
  endtask

  // One clock: advance the model across the edge, compare, then drive.
  task automatic step();
    logic [NUM_REQ-1:0] smp;
    int idx, win;
    smp = r_req;
    @(posedge clk);
    #1;
    cyc++;
    acked = '0;
    if (reset_n) begin
      if (cyc == g_edge + 1) begin
        if (g_wr && g_addr == ADDR_W'(PIO_DATA_REG_ADDR)) m_port = g_data[7:0];
        if (!g_wr) m_rsp = (g_addr == ADDR_W'(PIO_DATA_REG_ADDR)) ? DATA_W'(m_port) : '0;
        acked[g_id]   = 1'b1;
        granted[g_id] = 1'b0;
      end
      if (cyc >= ready_edge && smp != '0) begin
        win = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (ptr + k) % NUM_REQ;
          if (win < 0 && smp[idx]) win = idx;
        end
        g_edge       = cyc;
        ready_edge   = cyc + 3;
        g_id         = win;
        ptr          = win;
        g_wr         = r_wr[win];
        g_addr       = r_addr[win];
        g_data       = r_data[win];
        granted[win] = 1'b1;
      end
    end
    check_outputs();
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    r_req = '0;
    check_reset_outputs();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int n_ack2;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_addr[i] = '0;
      r_data[i] = '0;
    end
    hold_mode = 1'b0;
    rand_mode = 1'b0;
    cyc = 0;
    model_reset();

    step();
    check_reset_outputs();
    step();
    reset_n = 1'b1;
    run(2);

    // Single write of 0xA5
    raise(0, 1'b1, 2'd0, 32'h0000_00A5);
    step();
    chk("wr_cs", bus.m_chipselect, 1'b1);
    chk("wr_write_n", bus.m_write_n, 1'b0);
    step();
    chk("wr_cs_off", bus.m_chipselect, 1'b0);
    chk("wr_ack", bus.ack, 4'b0001);
    chk("wr_port", out_port, 8'hA5);
    run(2);

    // Read-back at address 0 and address 1
    raise(2, 1'b0, 2'd0, '0);
    run(2);
    chk("rd0_ack", bus.ack, 4'b0100);
    chk("rd0_data", bus.rsp_rdata, 32'h0000_00A5);
    run(2);
    raise(2, 1'b0, 2'd1, '0);
    run(2);
    chk("rd1_ack", bus.ack, 4'b0100);
    chk("rd1_data", bus.rsp_rdata, 32'h0);
    run(2);

    // Fairness after a skip: pointer at 1, requesters 0 and 3 together
    raise(1, 1'b1, 2'd1, 32'h77);
    run(2);
    chk("skip_ack1", bus.ack, 4'b0010);
    raise(0, 1'b1, 2'd0, 32'h0C);
    raise(3, 1'b1, 2'd0, 32'h03);
    run(3);
    chk("skip_first3", bus.ack, 4'b1000);
    chk("skip_port3", out_port, 8'h03);
    run(3);
    chk("skip_then0", bus.ack, 4'b0001);
    chk("skip_port0", out_port, 8'h0C);
    run(2);

    // Full contention from reset, each requester re-requesting immediately
    do_reset();
    hold_mode = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) raise(i, 1'b1, 2'd0, 32'h11 * (i + 1));
    for (int n = 0; n < 6; n++) begin
      run(2);
      chk("rot_ack", bus.ack, NUM_REQ'(1) << (n % NUM_REQ));
      chk("rot_port", out_port, 8'(8'h11 * ((n % NUM_REQ) + 1)));
      step();
    end
    hold_mode = 1'b0;
    r_req     = '0;
    granted   = '0;
    run(2);

    // Reset during ISSUE of a write
    raise(0, 1'b1, 2'd0, 32'h5A);
    step();
    chk("mid_cs", bus.m_chipselect, 1'b1);
    do_reset();
    raise(1, 1'b0, 2'd0, '0);
    run(2);
    chk("post_rst_ack", bus.ack, 4'b0010);
    chk("post_rst_rdata", bus.rsp_rdata, 32'h0);
    run(2);

    // One-cycle request from requester 2 while requester 0 is in ISSUE
    raise(0, 1'b0, 2'd0, '0);
    step();
    raise(2, 1'b0, 2'd0, '0);
    step();
    chk("wd_ack0", bus.ack, 4'b0001);
    r_req[2] = 1'b0;
    step();
    chk("wd_busy", bus.busy, 1'b0);
    n_ack2 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.ack[2]) n_ack2++;
    end
    chk("wd_no_ack2", n_ack2, 0);

    // Random traffic
    rand_mode = 1'b1;
    run(600);
    rand_mode = 1'b0;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
